// File: rtl/color_matrix_stage_pkg.sv
// Shared constants and helpers for the colour-correction matrix stage.
// Also provides the COEFF(i,j) slice macro for the packed row-major coefficient bus.
`ifndef COEFF
`define COEFF(i, j) ((((i) * 3) + (j)) * COEFF_WIDTH) +: COEFF_WIDTH
`endif

package color_matrix_stage_pkg;

  localparam int unsigned CCM_DATA_WIDTH  = 8;
  localparam int unsigned CCM_COEFF_WIDTH = 9;
  localparam int unsigned CCM_FRAC_BITS   = 6;
  localparam int unsigned CCM_TAPS        = 3;
  // Headroom bits on the dot-product sum so three full-scale products never wrap
  localparam int unsigned CCM_SUM_GUARD   = 2;

  function automatic int unsigned identity_coeff(input int unsigned row,
                                                 input int unsigned col,
                                                 input int unsigned frac);
    return (row == col) ? (32'd1 << frac) : 32'd0;
  endfunction

endpackage

// File: rtl/color_matrix_stage_dot.sv
// Three-tap dot product: unsigned pixel channels times signed coefficients.
module dot_product3 #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned B_WIDTH = 9,
  parameter int unsigned S_WIDTH = 19
) (
  input  logic [3*A_WIDTH-1:0]        a,
  input  logic [3*B_WIDTH-1:0]        b,
  output logic signed [S_WIDTH-1:0]   sum
);

  logic signed [S_WIDTH-1:0] ax;
  logic signed [S_WIDTH-1:0] bx;

  always_comb begin
    sum = '0;
    ax  = '0;
    bx  = '0;
    for (int k = 0; k < 3; k++) begin
      ax  = S_WIDTH'($signed({1'b0, a[k*A_WIDTH +: A_WIDTH]}));
      bx  = S_WIDTH'($signed(b[k*B_WIDTH +: B_WIDTH]));
      sum = sum + ax * bx;
    end
  end

endmodule

// File: rtl/color_matrix_stage_round_clamp.sv
// Round-half-up, arithmetic shift and clamp of a signed sum to pixel width.
module ccm_round_clamp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SUM_WIDTH  = 19,
  parameter int unsigned FRAC_BITS  = 6
) (
  input  logic signed [SUM_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0]       pix,
  output logic                        clip
);

  localparam int unsigned TW = SUM_WIDTH + 1;
  localparam logic [TW-1:0] RND = TW'(1) << (FRAC_BITS - 1);

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] v;

  always_comb begin
    t    = $signed({sum[SUM_WIDTH-1], sum} + RND);
    v    = t >>> FRAC_BITS;
    pix  = '0;
    clip = 1'b0;
    if (v[TW-1]) begin
      clip = 1'b1;
    end else if (|v[TW-2:DATA_WIDTH]) begin
      pix  = '1;
      clip = 1'b1;
    end else begin
      pix = v[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/color_matrix_stage.sv
// Pipelined 3x3 colour-correction matrix with frame-shadowed coefficients, latency 3.
// Optional CCM_SAT_COUNT_EN adds a per-frame count of clamped output pixels.
module color_matrix_stage
  import color_matrix_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = CCM_DATA_WIDTH,
  parameter int unsigned COEFF_WIDTH = CCM_COEFF_WIDTH,
  parameter int unsigned FRAC_BITS   = CCM_FRAC_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [9*COEFF_WIDTH-1:0]   coeff,
  input  logic                       dvi,
  input  logic                       fv_in,
  input  logic                       lv_in,
  input  logic [DATA_WIDTH-1:0]      r_in,
  input  logic [DATA_WIDTH-1:0]      g_in,
  input  logic [DATA_WIDTH-1:0]      b_in,
  output logic                       dvo,
  output logic                       fv_out,
  output logic                       lv_out,
  output logic [DATA_WIDTH-1:0]      r_out,
  output logic [DATA_WIDTH-1:0]      g_out,
  output logic [DATA_WIDTH-1:0]      b_out
`ifdef CCM_SAT_COUNT_EN
  ,
  output logic [31:0]                sat_count,
  output logic                       sat_count_valid
`endif
);

  localparam int unsigned SUM_WIDTH = DATA_WIDTH + COEFF_WIDTH + CCM_SUM_GUARD;
  localparam int unsigned ROW_WIDTH = CCM_TAPS * COEFF_WIDTH;
  localparam int unsigned PIX_WIDTH = CCM_TAPS * DATA_WIDTH;

  logic [9*COEFF_WIDTH-1:0]  shadow_coeff;
  logic                      shadow_en;
  logic                      v1, fv1, lv1;
  logic [PIX_WIDTH-1:0]      pix1;
  logic                      v2, fv2, lv2, en2;
  logic [PIX_WIDTH-1:0]      pix2;
  logic signed [SUM_WIDTH-1:0] sum_c [3];
  logic signed [SUM_WIDTH-1:0] sum2  [3];
  logic [DATA_WIDTH-1:0]     rc_pix [3];
  logic [2:0]                rc_clip;

  // Coefficients only follow the ports between frames, so a frame never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          shadow_coeff[`COEFF(i, j)] <= COEFF_WIDTH'(identity_coeff(i, j, FRAC_BITS));
        end
      end
      shadow_en <= 1'b0;
    end else if (!fv_in) begin
      shadow_coeff <= coeff;
      shadow_en    <= enable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      fv1  <= 1'b0;
      lv1  <= 1'b0;
      pix1 <= '0;
    end else begin
      v1   <= dvi;
      fv1  <= fv_in;
      lv1  <= lv_in;
      pix1 <= {b_in, g_in, r_in};
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    dot_product3 #(
      .A_WIDTH (DATA_WIDTH),
      .B_WIDTH (COEFF_WIDTH),
      .S_WIDTH (SUM_WIDTH)
    ) u_dot (
      .a   (pix1),
      .b   (shadow_coeff[i*ROW_WIDTH +: ROW_WIDTH]),
      .sum (sum_c[i])
    );

    ccm_round_clamp #(
      .DATA_WIDTH (DATA_WIDTH),
      .SUM_WIDTH  (SUM_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_rc (
      .sum  (sum2[i]),
      .pix  (rc_pix[i]),
      .clip (rc_clip[i])
    );
  end

  // The enable used by S3 travels with the pixel, immune to shadow updates after frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      v2   <= 1'b0;
      fv2  <= 1'b0;
      lv2  <= 1'b0;
      en2  <= 1'b0;
      pix2 <= '0;
      for (int i = 0; i < 3; i++) sum2[i] <= '0;
    end else begin
      v2   <= v1;
      fv2  <= fv1;
      lv2  <= lv1;
      en2  <= shadow_en;
      pix2 <= pix1;
      for (int i = 0; i < 3; i++) sum2[i] <= sum_c[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvo    <= 1'b0;
      fv_out <= 1'b0;
      lv_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
    end else begin
      dvo    <= v2;
      fv_out <= fv2;
      lv_out <= lv2;
      if (v2) begin
        r_out <= en2 ? rc_pix[0] : pix2[0 +: DATA_WIDTH];
        g_out <= en2 ? rc_pix[1] : pix2[DATA_WIDTH +: DATA_WIDTH];
        b_out <= en2 ? rc_pix[2] : pix2[2*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef CCM_SAT_COUNT_EN
  logic [31:0] sat_cnt;
  logic        frame_end_c;
  logic        sat_px_c;

  assign frame_end_c = fv_out & ~fv2;
  assign sat_px_c    = v2 & en2 & (|rc_clip);

  // A clamp landing on the frame-end cycle seeds the next frame's count
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt         <= '0;
      sat_count       <= '0;
      sat_count_valid <= 1'b0;
    end else begin
      sat_count_valid <= frame_end_c;
      if (frame_end_c) begin
        sat_count <= sat_cnt;
        sat_cnt   <= 32'(sat_px_c);
      end else if (sat_px_c && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_clip;
  assign unused_clip = |rc_clip;
`endif

endmodule

// File: tb/tb_color_matrix_stage.sv
// Scoreboard bench for color_matrix_stage: randomized frames against a per-frame matrix model.
module tb_color_matrix_stage;

  localparam int DW = 8;
  localparam int CW = 9;
  localparam int FB = 6;

  logic            clk = 1'b0;
  logic            reset, enable, dvi, fv_in, lv_in;
  logic [9*CW-1:0] coeff;
  logic [DW-1:0]   r_in, g_in, b_in;
  logic            dvo, fv_out, lv_out;
  logic [DW-1:0]   r_out, g_out, b_out;
`ifdef CCM_SAT_COUNT_EN
  logic [31:0]     sat_count;
  logic            sat_count_valid;
`endif

  always #5 clk = ~clk;

  color_matrix_stage dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .coeff   (coeff),
    .dvi     (dvi),
    .fv_in   (fv_in),
    .lv_in   (lv_in),
    .r_in    (r_in),
    .g_in    (g_in),
    .b_in    (b_in),
    .dvo     (dvo),
    .fv_out  (fv_out),
    .lv_out  (lv_out),
    .r_out   (r_out),
    .g_out   (g_out),
    .b_out   (b_out)
`ifdef CCM_SAT_COUNT_EN
    ,
    .sat_count       (sat_count),
    .sat_count_valid (sat_count_valid)
`endif
  );

  typedef struct {
    int r;
    int g;
    int b;
    bit clip;
  } px_t;

  int   vectors = 0;
  int   miscompares = 0;
  px_t  exp_q[$];
  int   ident[9] = '{64, 0, 0, 0, 64, 0, 0, 0, 64};
  int   mtx_a[9] = '{32, 32, 0, -64, 0, 0, 127, 127, 127};
  int   port_c[9];
  int   m_c[9];
  bit   m_en;
  bit [2:0] h_fv, h_lv, h_dv;
  bit   armed = 1'b0;
  bit   prev_fv;
  int   frame_clip;
  int   last_r, last_g, last_b;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int clampv(input int v, inout bit clip);
    if (v < 0) begin
      clip = 1'b1;
      return 0;
    end
    if (v > 255) begin
      clip = 1'b1;
      return 255;
    end
    return v;
  endfunction

  // Reference: matrix and enable latched at the last frame-blanking cycle, floor((s+32)/64)
  function automatic px_t model(input int r, input int g, input int b);
    px_t e;
    int  p[3];
    int  o[3];
    int  s;
    p = '{r, g, b};
    e.clip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!m_en) o[i] = p[i];
      else begin
        s = 0;
        for (int j = 0; j < 3; j++) s += m_c[i*3+j] * p[j];
        o[i] = clampv((s + (1 << (FB - 1))) >>> FB, e.clip);
      end
    end
    e.r = o[0];
    e.g = o[1];
    e.b = o[2];
    return e;
  endfunction

  task automatic set_coeff(input int c[9]);
    port_c = c;
    for (int k = 0; k < 9; k++) coeff[k*CW +: CW] = CW'(c[k]);
  endtask

  task automatic drive(input bit fv, input bit lv, input bit dv, input int r, input int g, input int b);
    @(posedge clk);
    #1;
    fv_in = fv;
    lv_in = lv;
    dvi   = dv;
    r_in  = DW'(r);
    g_in  = DW'(g);
    b_in  = DW'(b);
  endtask

  task automatic idle(input bit fv, input bit lv, input int n);
    repeat (n) drive(fv, lv, 1'b0, 0, 0, 0);
  endtask

  task automatic px(input int r, input int g, input int b);
    drive(1'b1, 1'b1, 1'b1, r, g, b);
    exp_q.push_back(model(r, g, b));
  endtask

  task automatic pxe(input int r, input int g, input int b,
                     input int er, input int eg, input int eb, input bit ec);
    px_t e;
    drive(1'b1, 1'b1, 1'b1, r, g, b);
    e.r = er;
    e.g = eg;
    e.b = eb;
    e.clip = ec;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    dvi   = 1'b0;
    fv_in = 1'b0;
    lv_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_frame();
    int c[9];
    for (int k = 0; k < 9; k++) c[k] = int'($urandom_range(0, 511)) - 256;
    set_coeff(c);
    enable = 1'($urandom_range(0, 1));
    idle(1'b0, 1'b0, 2);
    for (int ln = 0; ln < int'($urandom_range(1, 3)); ln++) begin
      idle(1'b1, 1'b0, 1);
      for (int n = 0; n < int'($urandom_range(1, 6)); n++) begin
        if ($urandom_range(0, 3) == 0) idle(1'b1, 1'b1, 2);
        if ($urandom_range(0, 7) == 0) begin
          for (int k = 0; k < 9; k++) c[k] = int'($urandom_range(0, 511)) - 256;
          set_coeff(c);
          enable = ~enable;
        end
        px(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      idle(1'b1, 1'b0, 1);
    end
    idle(1'b0, 1'b0, 1);
  endtask

  // Shadow model and sync delay line, both advanced at the active edge
  always @(posedge clk) begin
    if (reset) begin
      m_c = ident;
      m_en = 1'b0;
      exp_q.delete();
      h_fv = '0;
      h_lv = '0;
      h_dv = '0;
      prev_fv = 1'b0;
      frame_clip = 0;
      last_r = 0;
      last_g = 0;
      last_b = 0;
      armed = 1'b1;
    end else begin
      if (!fv_in) begin
        m_c = port_c;
        m_en = enable;
      end
      h_fv = {h_fv[1:0], fv_in};
      h_lv = {h_lv[1:0], lv_in};
      h_dv = {h_dv[1:0], dvi};
    end
  end

  always @(negedge clk) begin
    px_t e;
    if (armed) begin
      check("fv_out", fv_out, h_fv[2]);
      check("lv_out", lv_out, h_lv[2]);
      check("dvo", dvo, h_dv[2]);
      if (dvo) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("r_out", r_out, e.r);
          check("g_out", g_out, e.g);
          check("b_out", b_out, e.b);
          last_r = e.r;
          last_g = e.g;
          last_b = e.b;
          if (e.clip) frame_clip++;
        end
      end else begin
        check("r_hold", r_out, last_r);
        check("g_hold", g_out, last_g);
        check("b_hold", b_out, last_b);
      end
`ifdef CCM_SAT_COUNT_EN
      check("sat_count_valid", sat_count_valid, prev_fv && !fv_out);
      if (prev_fv && !fv_out) begin
        check("sat_count", sat_count, frame_clip);
        frame_clip = 0;
      end
`endif
      prev_fv = fv_out;
    end
  end

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    dvi = 1'b0;
    fv_in = 1'b0;
    lv_in = 1'b0;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    set_coeff(ident);
    do_reset();

    // identity, enabled
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    pxe(10, 200, 255, 10, 200, 255, 1'b0);
    pxe(0, 128, 1, 0, 128, 1, 1'b0);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 2);

    // rounding and clamps
    set_coeff(mtx_a);
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    pxe(3, 0, 0, 2, 0, 6, 1'b1);
    pxe(50, 0, 0, 25, 0, 99, 1'b1);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 2);

    // four fully clamping pixels in one frame
    idle(1'b1, 1'b0, 1);
    repeat (4) pxe(255, 255, 255, 255, 0, 255, 1'b1);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 3);

    // matrix change mid-frame only lands on the next frame
    set_coeff(ident);
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    pxe(77, 88, 99, 77, 88, 99, 1'b0);
    set_coeff(mtx_a);
    pxe(3, 0, 0, 3, 0, 0, 1'b0);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 1);
    idle(1'b1, 1'b0, 1);
    pxe(3, 0, 0, 2, 0, 6, 1'b1);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 2);

    // bypass with two-cycle bubbles
    enable = 1'b0;
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    pxe(255, 255, 255, 255, 255, 255, 1'b0);
    idle(1'b1, 1'b1, 2);
    pxe(1, 2, 3, 1, 2, 3, 1'b0);
    idle(1'b1, 1'b1, 2);
    pxe(50, 0, 9, 50, 0, 9, 1'b0);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 2);

    for (int f = 0; f < 25; f++) rand_frame();

    // reset mid-line, then an identity frame must pass pixels unchanged
    enable = 1'b1;
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    px(200, 10, 30);
    px(90, 250, 5);
    do_reset();
    set_coeff(ident);
    idle(1'b0, 1'b0, 2);
    idle(1'b1, 1'b0, 1);
    pxe(10, 200, 255, 10, 200, 255, 1'b0);
    pxe(255, 0, 128, 255, 0, 128, 1'b0);
    idle(1'b1, 1'b0, 1);
    idle(1'b0, 1'b0, 6);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
